// File: rtl/kb_ascii.sv
// kb_ascii: pops PS/2 Set-2 make codes from the scan FIFO, translates them to ASCII and tracks Caps Lock.
// Optional: define KB_ASCII_ARROWS_EN to translate E0-prefixed arrow keys into cursor codes 0x11-0x14.
module kb_ascii #(
  parameter bit CAPS_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fifo_empty_i,
  input  logic [8:0] rd_data_i,
  output logic       rd_fifo_o,
  output logic [7:0] ascii_o,
  output logic       ascii_valid_o,
  input  logic       ascii_ready_i,
  output logic       caps_lock_o
);

  typedef enum logic [1:0] {IDLE, MAP, OUT} state_e;

  state_e     state_q, state_d;
  logic [8:0] code_q, code_d;
  logic [6:0] ascii_q, ascii_d;
  logic       valid_q, valid_d;
  logic       caps_q, caps_d;
  logic [7:0] lookup;

  // Returns {hit, char}; letters are found as lowercase and folded to uppercase when Caps Lock is on.
  function automatic logic [7:0] mapCode(input logic [8:0] code, input logic caps);
    logic [6:0] ch;
    logic       hit;
    ch  = 7'h00;
    hit = 1'b1;
    if (!code[8]) begin
      case (code[7:0])
        8'h1C: ch = 7'h61;  8'h32: ch = 7'h62;  8'h21: ch = 7'h63;  8'h23: ch = 7'h64;
        8'h24: ch = 7'h65;  8'h2B: ch = 7'h66;  8'h34: ch = 7'h67;  8'h33: ch = 7'h68;
        8'h43: ch = 7'h69;  8'h3B: ch = 7'h6A;  8'h42: ch = 7'h6B;  8'h4B: ch = 7'h6C;
        8'h3A: ch = 7'h6D;  8'h31: ch = 7'h6E;  8'h44: ch = 7'h6F;  8'h4D: ch = 7'h70;
        8'h15: ch = 7'h71;  8'h2D: ch = 7'h72;  8'h1B: ch = 7'h73;  8'h2C: ch = 7'h74;
        8'h3C: ch = 7'h75;  8'h2A: ch = 7'h76;  8'h1D: ch = 7'h77;  8'h22: ch = 7'h78;
        8'h35: ch = 7'h79;  8'h1A: ch = 7'h7A;
        8'h45: ch = 7'h30;  8'h16: ch = 7'h31;  8'h1E: ch = 7'h32;  8'h26: ch = 7'h33;
        8'h25: ch = 7'h34;  8'h2E: ch = 7'h35;  8'h36: ch = 7'h36;  8'h3D: ch = 7'h37;
        8'h3E: ch = 7'h38;  8'h46: ch = 7'h39;
        8'h29: ch = 7'h20;  8'h5A: ch = 7'h0D;  8'h66: ch = 7'h08;  8'h76: ch = 7'h1B;
        default: hit = 1'b0;
      endcase
      // Only letters land in 0x60-0x7F, so the fold never touches digits or control codes.
      if (caps && ch[6:5] == 2'b11) ch[5] = 1'b0;
    end else begin
`ifdef KB_ASCII_ARROWS_EN
      case (code[7:0])
        8'h75:   ch = 7'h11;
        8'h72:   ch = 7'h12;
        8'h6B:   ch = 7'h13;
        8'h74:   ch = 7'h14;
        default: hit = 1'b0;
      endcase
`else
      hit = 1'b0;
`endif
    end
    return {hit, ch};
  endfunction

  // Pop strobe is gated by reset so the FIFO is never drained while the block is held in reset.
  assign rd_fifo_o = rst_n && (state_q == IDLE) && !fifo_empty_i;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    ascii_d = ascii_q;
    valid_d = valid_q;
    caps_d  = caps_q;
    lookup  = mapCode(code_q, caps_q);
    case (state_q)
      IDLE: begin
        if (rd_fifo_o) begin
          code_d  = rd_data_i;
          state_d = MAP;
        end
      end
      MAP: begin
        if (!code_q[8] && code_q[7:0] == 8'h58) begin
          caps_d  = ~caps_q;
          state_d = IDLE;
        end else if (lookup[7]) begin
          ascii_d = lookup[6:0];
          valid_d = 1'b1;
          state_d = OUT;
        end else begin
          state_d = IDLE;
        end
      end
      OUT: begin
        if (ascii_ready_i) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= 9'h000;
      ascii_q <= 7'h00;
      valid_q <= 1'b0;
      caps_q  <= CAPS_INIT;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      ascii_q <= ascii_d;
      valid_q <= valid_d;
      caps_q  <= caps_d;
    end
  end

  assign ascii_o       = {1'b0, ascii_q};
  assign ascii_valid_o = valid_q;
  assign caps_lock_o   = caps_q;

endmodule

// File: tb/tb_kb_ascii.sv
// Self-checking bench for kb_ascii: a FIFO model feeds make codes, a translation/timing model predicts
// every output each cycle, and directed scenarios pin the model with literal expected characters.
module tb_kb_ascii;

  localparam bit CapsInit = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       fifo_empty_i;
  logic [8:0] rd_data_i;
  logic       rd_fifo_o;
  logic [7:0] ascii_o;
  logic       ascii_valid_o;
  logic       ascii_ready_i;
  logic       caps_lock_o;

  kb_ascii #(.CAPS_INIT(CapsInit)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fifo_empty_i  (fifo_empty_i),
    .rd_data_i     (rd_data_i),
    .rd_fifo_o     (rd_fifo_o),
    .ascii_o       (ascii_o),
    .ascii_valid_o (ascii_valid_o),
    .ascii_ready_i (ascii_ready_i),
    .caps_lock_o   (caps_lock_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] ch;
    int         due;
  } pend_t;

  pend_t      expQ[$];
  logic [8:0] fifoQ[$];
  int         testCount = 0;
  int         failCount = 0;
  int         cycleNo = 0;
  int         popCount = 0;
  int         transfers = 0;
  int         busyUntil = 0;
  int         capsFlipAt = -1;
  bit         capsModel = CapsInit;
  bit         capsShown = CapsInit;
  bit         sawPop = 1'b0;
  logic [6:0] lastChar = 7'h00;

  byte unsigned letterCodes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  byte unsigned digitCodes[10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  // Returns the character for a word, -1 for a dropped word, -2 for the Caps Lock key.
  function automatic int translate(input logic [8:0] w, input bit caps);
    if (w[8]) begin
`ifdef KB_ASCII_ARROWS_EN
      case (w[7:0])
        8'h75:   return 'h11;
        8'h72:   return 'h12;
        8'h6B:   return 'h13;
        8'h74:   return 'h14;
        default: return -1;
      endcase
`else
      return -1;
`endif
    end
    if (w[7:0] == 8'h58) return -2;
    for (int i = 0; i < 26; i++)
      if (w[7:0] == letterCodes[i]) return (caps ? 'h41 : 'h61) + i;
    for (int i = 0; i < 10; i++)
      if (w[7:0] == digitCodes[i]) return 'h30 + i;
    case (w[7:0])
      8'h29:   return 'h20;
      8'h5A:   return 'h0D;
      8'h66:   return 'h08;
      8'h76:   return 'h1B;
      default: return -1;
    endcase
  endfunction

  task automatic expectEq(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Called once per cycle at the falling edge: compares every output with the model, then advances it.
  task automatic checkOutput();
    bit expValid;
    bit expRd;
    int r;
    if (capsFlipAt >= 0 && cycleNo >= capsFlipAt) begin
      capsShown  = capsModel;
      capsFlipAt = -1;
    end
    expValid = 1'b0;
    if (rst_n && expQ.size() > 0)
      if (cycleNo >= expQ[0].due) expValid = 1'b1;
    expRd = rst_n && !fifo_empty_i && expQ.size() == 0 && cycleNo >= busyUntil;
    expectEq("rd_fifo", 32'(rd_fifo_o), 32'(expRd));
    expectEq("ascii_valid", 32'(ascii_valid_o), 32'(expValid));
    expectEq("caps_lock", 32'(caps_lock_o), 32'(capsShown));
    if (expValid) expectEq("ascii", 32'(ascii_o), 32'({1'b0, expQ[0].ch}));
    sawPop = rd_fifo_o && !fifo_empty_i;
    if (sawPop) begin
      popCount++;
      busyUntil = cycleNo + 2;
      r = translate(rd_data_i, capsModel);
      if (r == -2) begin
        capsModel  = !capsModel;
        capsFlipAt = cycleNo + 2;
      end else if (r >= 0) begin
        expQ.push_back('{ch: r[6:0], due: cycleNo + 2});
      end
    end
    if (expValid && ascii_valid_o && ascii_ready_i) begin
      lastChar = expQ[0].ch;
      void'(expQ.pop_front());
      transfers++;
    end
    cycleNo++;
  endtask

  task automatic driveFifo();
    fifo_empty_i = (fifoQ.size() == 0);
    rd_data_i    = 9'h000;
    if (fifoQ.size() > 0) rd_data_i = fifoQ[0];
  endtask

  task automatic applyStimulus(input logic [8:0] w);
    fifoQ.push_back(w);
    driveFifo();
  endtask

  task automatic tick();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
    if (sawPop) void'(fifoQ.pop_front());
    driveFifo();
  endtask

  task automatic runUntil(input int target, output int cycles);
    cycles = 0;
    while (transfers < target && cycles < 300) begin
      tick();
      cycles++;
    end
    if (transfers < target) expectEq("timeout", 32'(transfers), 32'(target));
  endtask

  logic [8:0] burst[16] = '{9'h01C, 9'h032, 9'h021, 9'h023, 9'h024, 9'h045, 9'h016, 9'h01E,
                            9'h029, 9'h05A, 9'h066, 9'h076, 9'h02B, 9'h034, 9'h033, 9'h043};

  initial begin
    int cyc;
    int pops0;
    int xfer0;
    int n;
    fifo_empty_i  = 1'b1;
    rd_data_i     = 9'h000;
    ascii_ready_i = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    expectEq("reset_valid", 32'(ascii_valid_o), 32'd0);
    expectEq("reset_ascii", 32'(ascii_o), 32'h00);
    expectEq("reset_caps", 32'(caps_lock_o), 32'(CapsInit));
    expectEq("reset_rd_fifo", 32'(rd_fifo_o), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single 'a': one-cycle pop strobe, character two edges later, gone after the transfer.
    applyStimulus(9'h01C);
    #1;
    expectEq("pop_strobe", 32'(rd_fifo_o), 32'd1);
    tick();
    expectEq("pop_once", 32'(rd_fifo_o), 32'd0);
    expectEq("no_valid_in_map", 32'(ascii_valid_o), 32'd0);
    tick();
    expectEq("first_char_valid", 32'(ascii_valid_o), 32'd1);
    expectEq("first_char", 32'(ascii_o), 32'h61);
    tick();
    expectEq("first_char_done", 32'(ascii_valid_o), 32'd0);

    applyStimulus(9'h058);
    applyStimulus(9'h01C);
    runUntil(transfers + 1, cyc);
    expectEq("caps_on", 32'(caps_lock_o), 32'd1);
    expectEq("caps_upper_a", 32'(lastChar), 32'h41);
    applyStimulus(9'h058);
    applyStimulus(9'h045);
    runUntil(transfers + 1, cyc);
    expectEq("caps_off", 32'(caps_lock_o), 32'd0);
    expectEq("digit_zero", 32'(lastChar), 32'h30);

    // Back-pressure: 'b' must be held and 'c' left in the FIFO until ready rises.
    ascii_ready_i = 1'b0;
    pops0 = popCount;
    applyStimulus(9'h032);
    applyStimulus(9'h021);
    repeat (10) tick();
    expectEq("held_valid", 32'(ascii_valid_o), 32'd1);
    expectEq("held_char", 32'(ascii_o), 32'h62);
    expectEq("no_pop_while_held", 32'(popCount - pops0), 32'd1);
    expectEq("fifo_depth_held", 32'(fifoQ.size()), 32'd1);
    ascii_ready_i = 1'b1;
    runUntil(transfers + 2, cyc);
    expectEq("second_after_release", 32'(lastChar), 32'h63);

    pops0 = popCount;
    xfer0 = transfers;
    applyStimulus(9'h005);
    applyStimulus(9'h175);
    repeat (10) tick();
    expectEq("unmapped_pops", 32'(popCount - pops0), 32'd2);
`ifdef KB_ASCII_ARROWS_EN
    expectEq("arrow_up_xfer", 32'(transfers - xfer0), 32'd1);
    expectEq("arrow_up", 32'(lastChar), 32'h11);
`else
    expectEq("unmapped_silent", 32'(transfers - xfer0), 32'd0);
`endif

    // Reset while an Enter is held with Caps Lock on.
    ascii_ready_i = 1'b0;
    applyStimulus(9'h058);
    applyStimulus(9'h05A);
    n = 0;
    while (!ascii_valid_o && n < 50) begin
      tick();
      n++;
    end
    expectEq("enter_held", 32'(ascii_o), 32'h0D);
    expectEq("caps_before_reset", 32'(caps_lock_o), 32'd1);
    rst_n = 1'b0;
    #1;
    expectEq("rst_valid", 32'(ascii_valid_o), 32'd0);
    expectEq("rst_ascii", 32'(ascii_o), 32'h00);
    expectEq("rst_caps", 32'(caps_lock_o), 32'(CapsInit));
    expQ.delete();
    capsModel  = CapsInit;
    capsShown  = CapsInit;
    capsFlipAt = -1;
    busyUntil  = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    ascii_ready_i = 1'b1;
    applyStimulus(9'h024);
    runUntil(transfers + 1, cyc);
    expectEq("after_reset_char", 32'(lastChar), 32'h65);

    // Sixteen queued words with ready high: one character every three cycles.
    foreach (burst[i]) applyStimulus(burst[i]);
    runUntil(transfers + 16, cyc);
    expectEq("burst_cycles", 32'(cyc), 32'd48);
    expectEq("burst_last", 32'(lastChar), 32'h69);
    repeat (4) tick();
    expectEq("model_drained", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/kb_ascii.md
Name: kb_ascii

Overview:
- Consumer stage directly downstream of the keyboard scan-code FIFO.
- Pops 9-bit make-code words, translates PS/2 Set-2 make codes to 7-bit ASCII and tracks Caps Lock.
- Presents characters on a valid/ready interface to the text/display logic.
- Break codes are already removed upstream, so no Shift tracking: Caps Lock is the only case modifier.

Parameters:
- CAPS_INIT, 0, Caps Lock state after reset (0 = lowercase letters).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- fifo_empty  in  1  upstream FIFO empty flag.
- rd_data  in  9  FIFO head word, valid while fifo_empty=0. Bit 8 = extended (E0) flag; bits 7:0 = make code.
- rd_fifo  out  1  one-cycle pop strobe to the FIFO.
- ascii  out  8  character code; bit 7 always 0.
- ascii_valid  out  1  character available.
- ascii_ready  in  1  consumer accepts; transfer occurs on the edge where valid and ready are both 1.
- caps_lock  out  1  current Caps Lock state (drives LED).

Behaviour:
- Decided interface fact: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: rd_fifo=0, ascii=0x00, ascii_valid=0, caps_lock=CAPS_INIT, FSM=IDLE. Reset mid-operation discards any popped, unemitted code.
- FSM states: IDLE, MAP, OUT.
- IDLE:
  - If fifo_empty=0: register rd_data into code_q, assert rd_fifo for exactly this one cycle, go to MAP.
  - Otherwise stay in IDLE with rd_fifo=0.
- MAP: one cycle for registered lookup of code_q.
  - Caps code (bit8=0, 0x58): toggle caps_lock, go to IDLE, no output.
  - Mapped code: load ascii, set ascii_valid=1, go to OUT.
  - Unmapped code: go to IDLE silently.
- OUT:
  - Hold ascii and ascii_valid=1 stable until ascii_ready=1.
  - On the transfer edge: ascii_valid<=0, go to IDLE.
  - ascii_ready is ignored while ascii_valid=0.
- Latency and throughput:
  - Pop to ascii_valid: 2 cycles (IDLE pop edge, then MAP edge).
  - Minimum 3 cycles per character with ascii_ready tied high.
  - The FIFO is never popped while a character is pending (back-pressure held in OUT).
- Translation table, bit8=0 only:
  - Letters, Set-2 standard: 0x1C=a, 0x32=b, 0x21=c, ..., 0x1A=z. Output 0x61–0x7A if caps_lock=0, 0x41–0x5A if caps_lock=1.
  - Digits: 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46 map to '0'–'9' (0x30–0x39); unaffected by Caps Lock.
  - Control keys: 0x29 -> 0x20 (space), 0x5A -> 0x0D (enter), 0x66 -> 0x08 (backspace), 0x76 -> 0x1B (escape).
  - All other bit8=0 codes are unmapped.
- Extended words (bit8=1): handled only per the optional feature; otherwise unmapped.
- Boundary conditions:
  - FIFO becomes non-empty the same cycle the FSM returns to IDLE: the pop occurs on the next IDLE cycle.
  - Caps toggle while a character is in OUT is impossible, because the FSM is serialized.
  - fifo_empty deasserting for a single cycle is still a valid pop.

Optional Feature:
- Macro: KB_ASCII_ARROWS_EN.
- Defined: extended arrow keys map to cursor control codes, unaffected by Caps Lock. E0+0x75 (up) -> 0x11, E0+0x72 (down) -> 0x12, E0+0x6B (left) -> 0x13, E0+0x74 (right) -> 0x14. Other extended codes are dropped.
- Undefined: every word with bit8=1 is dropped in MAP; rd_fifo still pops it.

Test Plan:
- Reset with CAPS_INIT=0; push 0x01C; ascii_ready=1 -> rd_fifo pulses 1 cycle; 2 cycles later ascii=0x61, ascii_valid=1 for 1 cycle.
- Push 0x058, then 0x01C -> caps_lock goes 1 after MAP; ascii=0x41. Push 0x058, 0x045 -> caps_lock=0; ascii=0x30.
- ascii_ready=0; push 0x032, 0x021 -> ascii=0x62 held and FIFO not popped again. Raise ready -> 0x62 transfers, then 0x63 follows.
- Push unmapped 0x005 and 0x175 with macro undefined -> two pops, no ascii_valid. With KB_ASCII_ARROWS_EN defined, 0x175 -> ascii=0x11.
- Assert rst_n=0 during OUT holding 0x0D -> ascii_valid=0 and ascii=0x00 immediately; caps_lock returns to CAPS_INIT; next pop resumes normally.
- Back-to-back 16 words with ready high -> 16 characters in order, one per 3 cycles, no rd_fifo while fifo_empty=1.
